vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 1280x1024 VGA timing generator. Every horizontal and vertical interval and each sync polarity is a parameter, so one module serves all display modes. It adds a pixel clock-enable, registered glitch-free outputs, and line/frame start strobes. A configurable delay line aligns sync/valid/x/y with the latency of the downstream pixel pipeline (board/piece ROM lookup) that feeds the DAC.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_timing_gen_if.sv | 41 ++++
 rtl/vga_delay_line.sv | 38 +++
 rtl/vga_timing_gen.sv | 134 +++++++++++++
 tb/tb_vga_timing_gen.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (display mode sets) and the counter-width helper.
package vga_pkg;

    // 1280x1024 @ 60 Hz, positive syncs
    localparam int unsigned HActive1280 = 1280;
    localparam int unsigned HFp1280     = 48;
    localparam int unsigned HPw1280     = 112;
    localparam int unsigned HBp1280     = 248;
    localparam int unsigned VActive1280 = 1024;
    localparam int unsigned VFp1280     = 1;
    localparam int unsigned VPw1280     = 3;
    localparam int unsigned VBp1280     = 38;
    localparam bit          HPol1280    = 1'b1;
    localparam bit          VPol1280    = 1'b1;

    // 640x480 @ 60 Hz, negative syncs
    localparam int unsigned HActive640 = 640;
    localparam int unsigned HFp640     = 16;
    localparam int unsigned HPw640     = 96;
    localparam int unsigned HBp640     = 48;
    localparam int unsigned VActive640 = 480;
    localparam int unsigned VFp640     = 10;
    localparam int unsigned VPw640     = 2;
    localparam int unsigned VBp640     = 33;
    localparam bit          HPol640    = 1'b0;
    localparam bit          VPol640    = 1'b0;

    // Smallest counter width able to hold 0..max(h_total, v_total)-1.
    function automatic int unsigned cnt_width(input int unsigned h_total,
                                              input int unsigned v_total);
        int unsigned m;
        m = (h_total > v_total) ? h_total : v_total;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle driven by vga_timing_gen; frame_cnt exists only with VGA_FRAME_CNT_EN.
interface vga_timing_gen_if #(
    parameter int unsigned CNT_W = 11
);
    logic             hsync;
    logic             vsync;
    logic             valid;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
`endif

    modport master (
`ifdef VGA_FRAME_CNT_EN
        output frame_cnt,
`endif
        output hsync,
        output vsync,
        output valid,
        output x,
        output y,
        output line_start,
        output frame_start
    );

    modport slave (
`ifdef VGA_FRAME_CNT_EN
        input frame_cnt,
`endif
        input hsync,
        input vsync,
        input valid,
        input x,
        input y,
        input line_start,
        input frame_start
    );
endinterface

// File: rtl/vga_delay_line.sv
// ce-qualified DEPTH x WIDTH shift register with synchronous reset to RST_VAL.
// DEPTH = 0 degenerates to a wire.
module vga_delay_line #(
    parameter int unsigned       DEPTH   = 0,
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] delayed
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, ce};
        assign delayed     = data;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else if (ce) begin
                stage_q[0] <= data;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign delayed = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel ce, registered outputs and aligning delay line.
// Optional VGA_FRAME_CNT_EN adds a 16-bit frame counter on the interface.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = HActive1280,
    parameter int unsigned H_FP     = HFp1280,
    parameter int unsigned H_PW     = HPw1280,
    parameter int unsigned H_BP     = HBp1280,
    parameter int unsigned V_ACTIVE = VActive1280,
    parameter int unsigned V_FP     = VFp1280,
    parameter int unsigned V_PW     = VPw1280,
    parameter int unsigned V_BP     = VBp1280,
    parameter bit          H_POL    = HPol1280,
    parameter bit          V_POL    = VPol1280,
    parameter int unsigned PIPE_DLY = 0,
    parameter int unsigned CNT_W    = cnt_width(HActive1280 + HFp1280 + HPw1280 + HBp1280,
                                                VActive1280 + VFp1280 + VPw1280 + VBp1280)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    vga_timing_gen_if.master  vif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_PW + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_PW + V_BP;
    localparam int unsigned CW1     = CNT_W + 1;

    localparam logic [CNT_W-1:0] HLast = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] VLast = CNT_W'(V_TOTAL - 1);

    // Decode thresholds carry one spare bit so an end boundary equal to 2^CNT_W cannot alias.
    localparam logic [CNT_W:0] HActEnd = CW1'(H_ACTIVE);
    localparam logic [CNT_W:0] HsBeg   = CW1'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] HsEnd   = CW1'(H_ACTIVE + H_FP + H_PW);
    localparam logic [CNT_W:0] VActEnd = CW1'(V_ACTIVE);
    localparam logic [CNT_W:0] VsBeg   = CW1'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] VsEnd   = CW1'(V_ACTIVE + V_FP + V_PW);

    // Payload order: {hsync, vsync, valid, x, y, line_start, frame_start}
    localparam int unsigned      PayW   = 5 + 2 * CNT_W;
    localparam logic [PayW-1:0]  RstVal = {~H_POL, ~V_POL, {(PayW - 2){1'b0}}};

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (ce) begin
            if (h_q == HLast) begin
                h_d = '0;
                v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    logic [CNT_W:0]   h_ext, v_ext;
    logic             act_raw, hs_raw, vs_raw, ls_raw, fs_raw;
    logic [CNT_W-1:0] x_raw, y_raw;

    always_comb begin
        h_ext   = {1'b0, h_q};
        v_ext   = {1'b0, v_q};
        act_raw = (h_ext < HActEnd) && (v_ext < VActEnd);
        hs_raw  = (h_ext >= HsBeg) && (h_ext < HsEnd);
        vs_raw  = (v_ext >= VsBeg) && (v_ext < VsEnd);
        ls_raw  = (h_q == '0) && (v_ext < VActEnd);
        fs_raw  = (h_q == '0) && (v_q == '0);
        x_raw   = act_raw ? h_q : '0;
        y_raw   = act_raw ? v_q : '0;
    end

    // Stage 0: polarity is applied here so every later stage carries line-level values.
    logic [PayW-1:0] stage0_d, stage0_q;

    assign stage0_d = {hs_raw ? H_POL : ~H_POL,
                       vs_raw ? V_POL : ~V_POL,
                       act_raw, x_raw, y_raw, ls_raw, fs_raw};

    always_ff @(posedge clk) begin
        if (rst) begin
            stage0_q <= RstVal;
        end else if (ce) begin
            stage0_q <= stage0_d;
        end
    end

    logic [PayW-1:0] pipe_out;

    vga_delay_line #(
        .DEPTH   (PIPE_DLY),
        .WIDTH   (PayW),
        .RST_VAL (RstVal)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .data    (stage0_q),
        .delayed (pipe_out)
    );

    assign {vif.hsync, vif.vsync, vif.valid, vif.x, vif.y,
            vif.line_start, vif.frame_start} = pipe_out;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Counts the frame_start leaving the last stage, so it stays aligned with the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (ce && pipe_out[0]) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign vif.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: tiny mode at two pipeline depths plus a negative-polarity 640-wide mode.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(4))  vif0 ();
    vga_timing_gen_if #(.CNT_W(4))  vif3 ();
    vga_timing_gen_if #(.CNT_W(10)) vifv ();

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_PW(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_PW(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_DLY(0), .CNT_W(4)
    ) dut0 (.clk(clk), .rst(rst), .ce(ce), .vif(vif0));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_PW(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_PW(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_DLY(3), .CNT_W(4)
    ) dut3 (.clk(clk), .rst(rst), .ce(ce), .vif(vif3));

    // 640-pixel horizontal timing, short 8-line frame, negative syncs
    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_PW(96), .H_BP(48),
        .V_ACTIVE(4), .V_FP(1), .V_PW(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .PIPE_DLY(0), .CNT_W(10)
    ) dutv (.clk(clk), .rst(rst), .ce(ce), .vif(vifv));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ce  = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (vif0.valid !== 1'b0 || vif0.x !== 4'd0 || vif0.y !== 4'd0) begin
            fails++;
            $display("FAIL rst_xyv: got v=%b x=%0d y=%0d expected 0/0/0",
                     vif0.valid, vif0.x, vif0.y);
        end
        tests++;
        if ({vif0.hsync, vif0.vsync, vif0.line_start, vif0.frame_start} !== 4'b0000) begin
            fails++;
            $display("FAIL rst_sync0: got %b expected 0000",
                     {vif0.hsync, vif0.vsync, vif0.line_start, vif0.frame_start});
        end
        tests++;
        if ({vif3.hsync, vif3.valid, vif3.frame_start} !== 3'b000) begin
            fails++;
            $display("FAIL rst_dly3: got %b expected 000",
                     {vif3.hsync, vif3.valid, vif3.frame_start});
        end
        tests++;
        if ({vifv.hsync, vifv.vsync, vifv.valid} !== 3'b110) begin
            fails++;
            $display("FAIL rst_negpol: got %b expected 110",
                     {vifv.hsync, vifv.vsync, vifv.valid});
        end
    endtask

    task automatic test_tiny_frame();
        int va0 = 0, hs0 = 0, vs0 = 0, fs0 = 0, ls0 = 0, hsf0 = -1, vsf0 = -1;
        int va3 = 0, hs3 = 0, fs3 = 0, ls3 = 0, hsf3 = -1;
        do_reset();
        rst = 1'b0;
        tests++;
        if (vif0.valid !== 1'b0 || vif0.x !== 4'd0 || vif0.frame_start !== 1'b0) begin
            fails++;
            $display("FAIL release_k0: got v=%b x=%0d fs=%b expected 0/0/0",
                     vif0.valid, vif0.x, vif0.frame_start);
        end
        for (int k = 1; k <= 132; k++) begin
            tick();
            if (k <= 128) begin
                if (vif0.valid) va0++;
                if (vif0.hsync) hs0++;
                if (vif0.vsync) vs0++;
                if (vif0.frame_start) fs0++;
                if (vif0.line_start) ls0++;
                if (vif0.hsync && hsf0 < 0) hsf0 = k;
                if (vif0.vsync && vsf0 < 0) vsf0 = k;
            end
            if (k >= 4 && k <= 131) begin
                if (vif3.valid) va3++;
                if (vif3.hsync) hs3++;
                if (vif3.frame_start) fs3++;
                if (vif3.line_start) ls3++;
                if (vif3.hsync && hsf3 < 0) hsf3 = k;
            end
            if (k == 1) begin
                tests++;
                if ({vif0.valid, vif0.frame_start, vif0.line_start} !== 3'b111 ||
                    vif0.x !== 4'd0 || vif0.y !== 4'd0) begin
                    fails++;
                    $display("FAIL first_pixel: got v/fs/ls=%b x=%0d y=%0d expected 111 0 0",
                             {vif0.valid, vif0.frame_start, vif0.line_start}, vif0.x, vif0.y);
                end
            end
            if (k == 2) begin
                tests++;
                if (vif0.x !== 4'd1 || vif0.frame_start !== 1'b0 || vif0.line_start !== 1'b0) begin
                    fails++;
                    $display("FAIL second_pixel: got x=%0d fs=%b ls=%b expected 1 0 0",
                             vif0.x, vif0.frame_start, vif0.line_start);
                end
            end
            if (k == 56) begin
                tests++;
                if (vif0.valid !== 1'b1 || vif0.x !== 4'd7 || vif0.y !== 4'd3) begin
                    fails++;
                    $display("FAIL last_pixel0: got v=%b x=%0d y=%0d expected 1 7 3",
                             vif0.valid, vif0.x, vif0.y);
                end
            end
            if (k == 57) begin
                tests++;
                if (vif0.valid !== 1'b0 || vif0.x !== 4'd0 || vif0.y !== 4'd0) begin
                    fails++;
                    $display("FAIL blank_xy: got v=%b x=%0d y=%0d expected 0 0 0",
                             vif0.valid, vif0.x, vif0.y);
                end
            end
            if (k == 129) begin
                tests++;
                if (vif0.frame_start !== 1'b1) begin
                    fails++;
                    $display("FAIL frame_period0: got fs=%b expected 1", vif0.frame_start);
                end
            end
            if (k == 3) begin
                tests++;
                if (vif3.valid !== 1'b0 || vif3.frame_start !== 1'b0) begin
                    fails++;
                    $display("FAIL dly3_early: got v=%b fs=%b expected 0 0",
                             vif3.valid, vif3.frame_start);
                end
            end
            if (k == 4) begin
                tests++;
                if (vif3.valid !== 1'b1 || vif3.frame_start !== 1'b1) begin
                    fails++;
                    $display("FAIL dly3_first: got v=%b fs=%b expected 1 1",
                             vif3.valid, vif3.frame_start);
                end
            end
            if (k == 59) begin
                tests++;
                if (vif3.valid !== 1'b1 || vif3.x !== 4'd7 || vif3.y !== 4'd3) begin
                    fails++;
                    $display("FAIL dly3_last_pixel: got v=%b x=%0d y=%0d expected 1 7 3",
                             vif3.valid, vif3.x, vif3.y);
                end
            end
            if (k == 132) begin
                tests++;
                if (vif3.frame_start !== 1'b1) begin
                    fails++;
                    $display("FAIL dly3_period: got fs=%b expected 1", vif3.frame_start);
                end
            end
        end
        tests++;
        if (va0 != 32 || hs0 != 24 || vs0 != 32 || fs0 != 1 || ls0 != 4) begin
            fails++;
            $display("FAIL counts0: got va=%0d hs=%0d vs=%0d fs=%0d ls=%0d expected 32 24 32 1 4",
                     va0, hs0, vs0, fs0, ls0);
        end
        tests++;
        if (hsf0 != 11 || vsf0 != 81) begin
            fails++;
            $display("FAIL sync_start0: got hs@%0d vs@%0d expected 11 81", hsf0, vsf0);
        end
        tests++;
        if (va3 != 32 || hs3 != 24 || fs3 != 1 || ls3 != 4 || hsf3 != 14) begin
            fails++;
            $display("FAIL counts3: got va=%0d hs=%0d fs=%0d ls=%0d hs@%0d expected 32 24 1 4 14",
                     va3, hs3, fs3, ls3, hsf3);
        end
    endtask

    task automatic test_ce_toggle();
        int fs = 0, ls = 0, va = 0, hs = 0;
        do_reset();
        rst = 1'b0;
        ce  = 1'b1;
        for (int j = 1; j <= 257; j++) begin
            tick();
            if (j <= 256) begin
                if (vif0.frame_start) fs++;
                if (vif0.line_start) ls++;
                if (vif0.valid) va++;
                if (vif0.hsync) hs++;
            end
            if (j == 2) begin
                tests++;
                if (vif0.frame_start !== 1'b1 || vif0.x !== 4'd0) begin
                    fails++;
                    $display("FAIL ce_hold_strobe: got fs=%b x=%0d expected 1 0",
                             vif0.frame_start, vif0.x);
                end
            end
            if (j == 5) begin
                tests++;
                if (vif0.x !== 4'd2 || vif0.frame_start !== 1'b0) begin
                    fails++;
                    $display("FAIL ce_advance: got x=%0d fs=%b expected 2 0",
                             vif0.x, vif0.frame_start);
                end
            end
            if (j == 257) begin
                tests++;
                if (vif0.frame_start !== 1'b1) begin
                    fails++;
                    $display("FAIL ce_period: got fs=%b expected 1", vif0.frame_start);
                end
            end
            ce = (j % 2 == 0);
        end
        ce = 1'b1;
        tests++;
        if (fs != 2 || ls != 8 || va != 64 || hs != 48) begin
            fails++;
            $display("FAIL ce_counts: got fs=%0d ls=%0d va=%0d hs=%0d expected 2 8 64 48",
                     fs, ls, va, hs);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        rst = 1'b0;
        for (int k = 1; k <= 41; k++) tick();
        // counter now at h=9, v=2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({vif0.hsync, vif0.vsync, vif0.valid} !== 3'b000 || vif0.x !== 4'd0 ||
            vif0.y !== 4'd0) begin
            fails++;
            $display("FAIL midrst_dut0: got hs/vs/v=%b x=%0d y=%0d expected 000 0 0",
                     {vif0.hsync, vif0.vsync, vif0.valid}, vif0.x, vif0.y);
        end
        tests++;
        if (vif3.valid !== 1'b0 || vif3.x !== 4'd0 || vif3.y !== 4'd0) begin
            fails++;
            $display("FAIL midrst_dly3: got v=%b x=%0d y=%0d expected 0 0 0",
                     vif3.valid, vif3.x, vif3.y);
        end
        tick();
        tests++;
        if (vif0.frame_start !== 1'b1 || vif0.valid !== 1'b1 || vif0.x !== 4'd0) begin
            fails++;
            $display("FAIL midrst_restart0: got fs=%b v=%b x=%0d expected 1 1 0",
                     vif0.frame_start, vif0.valid, vif0.x);
        end
        tests++;
        if (vif3.valid !== 1'b0) begin
            fails++;
            $display("FAIL midrst_flush3: got v=%b expected 0", vif3.valid);
        end
        tick();
        tick();
        tests++;
        if (vif3.frame_start !== 1'b0) begin
            fails++;
            $display("FAIL midrst_early3: got fs=%b expected 0", vif3.frame_start);
        end
        tick();
        tests++;
        if (vif3.frame_start !== 1'b1 || vif3.valid !== 1'b1) begin
            fails++;
            $display("FAIL midrst_restart3: got fs=%b v=%b expected 1 1",
                     vif3.frame_start, vif3.valid);
        end
    endtask

    task automatic test_polarity_640();
        int hsl = 0, vsl = 0, va = 0, fs = 0, ls = 0, hsf = -1;
        do_reset();
        rst = 1'b0;
        for (int k = 1; k <= 6401; k++) begin
            tick();
            if (k <= 6400) begin
                if (!vifv.hsync) hsl++;
                if (!vifv.vsync) vsl++;
                if (vifv.valid) va++;
                if (vifv.frame_start) fs++;
                if (vifv.line_start) ls++;
                if (!vifv.hsync && hsf < 0) hsf = k;
            end
            if (k == 6401) begin
                tests++;
                if (vifv.frame_start !== 1'b1) begin
                    fails++;
                    $display("FAIL neg_period: got fs=%b expected 1", vifv.frame_start);
                end
            end
        end
        tests++;
        if (hsl != 768 || hsf != 657) begin
            fails++;
            $display("FAIL neg_hsync: got low=%0d first=%0d expected 768 657", hsl, hsf);
        end
        tests++;
        if (vsl != 1600) begin
            fails++;
            $display("FAIL neg_vsync: got low=%0d expected 1600", vsl);
        end
        tests++;
        if (va != 2560 || fs != 1 || ls != 4) begin
            fails++;
            $display("FAIL neg_counts: got va=%0d fs=%0d ls=%0d expected 2560 1 4", va, fs, ls);
        end
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt();
        do_reset();
        tests++;
        if (vif0.frame_cnt !== 16'd0) begin
            fails++;
            $display("FAIL fcnt_reset: got %0d expected 0", vif0.frame_cnt);
        end
        rst = 1'b0;
        for (int k = 1; k <= 258; k++) begin
            tick();
            if (k == 2) begin
                tests++;
                if (vif0.frame_cnt !== 16'd1) begin
                    fails++;
                    $display("FAIL fcnt_first: got %0d expected 1", vif0.frame_cnt);
                end
            end
            if (k == 258) begin
                tests++;
                if (vif0.frame_cnt !== 16'd3) begin
                    fails++;
                    $display("FAIL fcnt_three: got %0d expected 3", vif0.frame_cnt);
                end
            end
        end
        rst = 1'b1;
        tick();
        tests++;
        if (vif0.frame_cnt !== 16'd0) begin
            fails++;
            $display("FAIL fcnt_clear: got %0d expected 0", vif0.frame_cnt);
        end
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_tiny_frame();
        test_ce_toggle();
        test_mid_reset();
        test_polarity_640();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
